byte_mem_arbiter: RTL and testbench

BYTE_MEM_ARBITER -- requirements
Module: byte_mem_arbiter

---
 rtl/byte_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_byte_mem_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/byte_mem_arbiter.sv
// byte_mem_arbiter: two-requester arbiter onto one byte-wide memory port, with round-robin
// grant, hold-grant lock and an in-order read return pipeline.
// Define BYTE_MEM_ARB_LOCK_TIMEOUT_EN to build the forced lock release after LOCK_TIMEOUT idle cycles.
module byte_mem_arbiter #(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_rd,
    input  logic [1:0]  req_wr,
    input  logic [1:0]  req_lock,
    input  logic [63:0] req_addr,
    input  logic [15:0] req_wr_data,
    output logic [1:0]  req_ack,
    output logic [1:0]  req_rd_valid,
    output logic [15:0] req_rd_data,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wr_data,
    input  logic [7:0]  mem_rd_data,
    output logic        lock_timeout
);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_lock_id;
    logic                    w_lock_id_nxt;
    logic                    r_rr;
    logic                    w_rr_nxt;
    logic [1:0]              w_req;
    logic [1:0]              w_lock_req;
    logic                    w_held;
    logic                    w_force;
    logic                    w_gnt_vld;
    logic                    w_gnt_id;
    logic                    w_gnt_wr;
    logic [READ_LATENCY-1:0] r_pv;
    logic [READ_LATENCY-1:0] r_pid;
    logic [1:0]              r_rd_valid;
    logic [15:0]             r_rd_data;

    if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
        $error("byte_mem_arbiter: READ_LATENCY must be 1..8");
    end
    if (LOCK_TIMEOUT < 1) begin : g_bad_timeout
        $error("byte_mem_arbiter: LOCK_TIMEOUT must be at least 1");
    end

    assign w_req = req_rd | req_wr;

`ifdef BYTE_MEM_ARB_LOCK_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_timeout;
    logic             r_ign;
    logic             r_ign_id;

    // After a forced release the old owner's lock is masked until it is seen low
    assign w_lock_req   = r_ign ? (req_lock & ~(2'b01 << r_ign_id)) : req_lock;
    assign w_force      = w_held && !w_gnt_vld &&
                          ((r_to_cnt + CNT_W'(1)) == CNT_W'(LOCK_TIMEOUT));
    assign lock_timeout = r_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
            r_ign     <= 1'b0;
            r_ign_id  <= 1'b0;
        end else begin
            if (w_held && !w_gnt_vld && !w_force) begin
                r_to_cnt <= r_to_cnt + CNT_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
            if (w_force) begin
                r_timeout <= 1'b1;
                r_ign     <= 1'b1;
                r_ign_id  <= r_lock_id;
            end else if (r_ign && !req_lock[r_ign_id]) begin
                r_ign     <= 1'b0;
            end
        end
    end
`else
    assign w_lock_req   = req_lock;
    assign w_force      = 1'b0;
    assign lock_timeout = 1'b0;
`endif

    // Arbitration, lock next-state and memory-side drive
    always_comb begin
        w_held        = 1'b0;
        w_gnt_vld     = 1'b0;
        w_gnt_id      = 1'b0;
        w_gnt_wr      = 1'b0;
        w_state_nxt   = ST_UNLOCKED;
        w_lock_id_nxt = r_lock_id;
        w_rr_nxt      = r_rr;
        req_ack       = 2'b00;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = 32'h0;
        mem_wr_data   = 8'h0;

        w_held = (r_state == ST_LOCKED) && w_lock_req[r_lock_id];
        if (w_held) begin
            w_gnt_vld = w_req[r_lock_id];
            w_gnt_id  = r_lock_id;
        end else if (w_req == 2'b11) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = r_rr;
        end else if (w_req != 2'b00) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = w_req[1];
        end
        w_gnt_wr = req_wr[w_gnt_id];

        if (w_gnt_vld) begin
            w_rr_nxt = ~w_gnt_id;
        end
        if (w_gnt_vld && w_lock_req[w_gnt_id]) begin
            w_state_nxt   = ST_LOCKED;
            w_lock_id_nxt = w_gnt_id;
        end else if (w_held && !w_force) begin
            w_state_nxt   = ST_LOCKED;
        end

        if (reset_n && w_gnt_vld) begin
            req_ack     = 2'b01 << w_gnt_id;
            mem_rd      = !w_gnt_wr;
            mem_wr      = w_gnt_wr;
            mem_addr    = w_gnt_id ? req_addr[63:32] : req_addr[31:0];
            mem_wr_data = w_gnt_id ? req_wr_data[15:8] : req_wr_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_UNLOCKED;
            r_lock_id <= 1'b0;
            r_rr      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_id <= w_lock_id_nxt;
            r_rr      <= w_rr_nxt;
        end
    end

    // Read return pipeline: valid + requester id only, data captured from memory at the tail
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pv       <= '0;
            r_pid      <= '0;
            r_rd_valid <= 2'b00;
            r_rd_data  <= 16'h0;
        end else begin
            r_pv[0]  <= w_gnt_vld && !w_gnt_wr;
            r_pid[0] <= w_gnt_id;
            for (int unsigned k = 1; k < READ_LATENCY; k++) begin
                r_pv[k]  <= r_pv[k-1];
                r_pid[k] <= r_pid[k-1];
            end
            r_rd_valid <= 2'b00;
            if (r_pv[READ_LATENCY-1]) begin
                r_rd_valid <= 2'b01 << r_pid[READ_LATENCY-1];
                if (r_pid[READ_LATENCY-1]) begin
                    r_rd_data[15:8] <= mem_rd_data;
                end else begin
                    r_rd_data[7:0]  <= mem_rd_data;
                end
            end
        end
    end

    assign req_rd_valid = r_rd_valid;
    assign req_rd_data  = r_rd_data;

endmodule

// File: tb/tb_byte_mem_arbiter.sv
// tb_byte_mem_arbiter: directed self-checking bench for byte_mem_arbiter (READ_LATENCY=2, LOCK_TIMEOUT=4).
// Expectations for the lock-timeout case follow BYTE_MEM_ARB_LOCK_TIMEOUT_EN.
module tb_byte_mem_arbiter;

`ifdef BYTE_MEM_ARB_LOCK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic        v;
        logic        id;
        logic [31:0] a;
    } rec_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_rd, req_wr, req_lock;
    logic [63:0] req_addr;
    logic [15:0] req_wr_data;
    logic [1:0]  req_ack, req_rd_valid;
    logic [15:0] req_rd_data;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wr_data;
    logic [7:0]  mem_rd_data;
    logic        lock_timeout;

    int n_chk  = 0;
    int n_pass = 0;

    rec_t        mh [0:1];
    rec_t        ah [0:2];
    logic [15:0] exp_rdata;
    logic        exp_lto;

    byte_mem_arbiter #(
        .READ_LATENCY (2),
        .LOCK_TIMEOUT (4)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_lock     (req_lock),
        .req_addr     (req_addr),
        .req_wr_data  (req_wr_data),
        .req_ack      (req_ack),
        .req_rd_valid (req_rd_valid),
        .req_rd_data  (req_rd_data),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data),
        .lock_timeout (lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_val(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) mh[i] = '0;
        for (int i = 0; i < 3; i++) ah[i] = '0;
        exp_rdata = 16'h0;
        exp_lto   = 1'b0;
    endtask

    // One cycle with reset held low and both requesters active: every output must read 0
    task automatic rst_cyc();
        @(negedge clk);
        reset_n     = 1'b0;
        req_rd      = 2'b11;
        req_wr      = 2'b00;
        req_lock    = 2'b11;
        req_addr    = {32'h700, 32'h600};
        req_wr_data = 16'h0;
        mem_rd_data = 8'hEE;
        #1;
        clear_model();
        check("rst_ack", req_ack, 2'b00);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wr_data", mem_wr_data, 8'h0);
        check("rst_rd_valid", req_rd_valid, 2'b00);
        check("rst_rd_data", req_rd_data, 16'h0);
        check("rst_lock_timeout", lock_timeout, 1'b0);
    endtask

    // One normal cycle: drive requests, check grant/memory side and any due read return
    task automatic cyc(input logic [1:0] rd, input logic [1:0] wr, input logic [1:0] lk,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] eack);
        logic       id;
        logic       act;
        logic [1:0] ev;
        @(negedge clk);
        reset_n     = 1'b1;
        req_rd      = rd;
        req_wr      = wr;
        req_lock    = lk;
        req_addr    = {a1, a0};
        req_wr_data = {d1, d0};
        mem_rd_data = mh[1].v ? mem_val(mh[1].a) : 8'hEE;
        #1;
        ev = 2'b00;
        if (ah[2].v) begin
            ev = 2'b01 << ah[2].id;
            if (ah[2].id) exp_rdata[15:8] = mem_val(ah[2].a);
            else          exp_rdata[7:0]  = mem_val(ah[2].a);
        end
        id  = eack[1];
        act = (eack != 2'b00);
        check("ack", req_ack, eack);
        check("mem_rd", mem_rd, act && rd[id] && !wr[id]);
        check("mem_wr", mem_wr, act && wr[id]);
        if (act) check("mem_addr", mem_addr, id ? a1 : a0);
        if (act && wr[id]) check("mem_wr_data", mem_wr_data, id ? d1 : d0);
        check("rd_valid", req_rd_valid, ev);
        check("rd_data", req_rd_data, exp_rdata);
        check("lock_timeout", lock_timeout, exp_lto);
        mh[1] = mh[0];
        mh[0] = '{v: mem_rd, id: 1'b0, a: mem_addr};
        ah[2] = ah[1];
        ah[1] = ah[0];
        ah[0] = '{v: act && rd[id] && !wr[id], id: id, a: (id ? a1 : a0)};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h0, 8'h0, 2'b00);
    endtask

    initial begin
        reset_n     = 1'b1;
        req_rd      = 2'b00;
        req_wr      = 2'b00;
        req_lock    = 2'b00;
        req_addr    = 64'h0;
        req_wr_data = 16'h0;
        mem_rd_data = 8'h0;
        clear_model();
        #1 reset_n = 1'b0;
        rst_cyc();
        rst_cyc();

        // Continuous reads from both: alternating grants starting with r0
        for (int i = 0; i < 6; i++)
            cyc(2'b11, 2'b00, 2'b00, 32'h100, 32'h200, 8'h0, 8'h0, (i % 2 == 0) ? 2'b01 : 2'b10);
        idle(4);

        // r0 locked writes stall r1 until r0 drops lock
        cyc(2'b10, 2'b01, 2'b01, 32'h10,  32'h300, 8'hAA, 8'h0, 2'b01);
        cyc(2'b10, 2'b01, 2'b01, 32'h11,  32'h300, 8'hBB, 8'h0, 2'b01);
        cyc(2'b10, 2'b00, 2'b01, 32'h0,   32'h300, 8'h0,  8'h0, 2'b00);
        cyc(2'b10, 2'b01, 2'b01, 32'h12,  32'h300, 8'hCC, 8'h0, 2'b01);
        cyc(2'b10, 2'b01, 2'b01, 32'h13,  32'h300, 8'hDD, 8'h0, 2'b01);
        cyc(2'b10, 2'b00, 2'b00, 32'h0,   32'h300, 8'h0,  8'h0, 2'b10);
        idle(4);

        // Read and write together is a write with no read return
        cyc(2'b10, 2'b10, 2'b00, 32'h0, 32'h40, 8'h0, 8'h5A, 2'b10);
        idle(4);

        // Read in flight when reset pulses: discarded, and r0 wins the first contest afterwards
        cyc(2'b01, 2'b00, 2'b00, 32'h500, 32'h0, 8'h0, 8'h0, 2'b01);
        rst_cyc();
        cyc(2'b11, 2'b00, 2'b00, 32'h600, 32'h700, 8'h0, 8'h0, 2'b01);
        idle(5);

        // r0 locks then idles with lock held while r1 waits
        cyc(2'b00, 2'b01, 2'b01, 32'h20, 32'h0, 8'h11, 8'h0, 2'b01);
        for (int i = 0; i < 4; i++)
            cyc(2'b10, 2'b00, 2'b01, 32'h0, 32'h900, 8'h0, 8'h0, 2'b00);
        if (TO_EN) exp_lto = 1'b1;
        cyc(2'b10, 2'b00, 2'b01, 32'h0, 32'h900, 8'h0, 8'h0, TO_EN ? 2'b10 : 2'b00);
        cyc(2'b10, 2'b00, 2'b01, 32'h0, 32'h901, 8'h0, 8'h0, TO_EN ? 2'b10 : 2'b00);
        cyc(2'b10, 2'b00, 2'b00, 32'h0, 32'h902, 8'h0, 8'h0, 2'b10);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
